// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports, write-to-read bypass,
// pending-load scoreboard and a sequenced soft-clear engine.
module register_file_mp #(
  parameter int unsigned        DATA_W  = 16,
  parameter int unsigned        ADDR_W  = 3,
  parameter int unsigned        SP_IDX  = 6,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(16'h0FFF),
  parameter bit                 BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd0_busy,
  output logic              rd1_busy,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SpAddr   = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                clr_done_q, clr_done_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                bypass_on;
  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];
  logic                rd_busy [2];

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        // wr1 first so wr0 overwrites on an address collision; wr1 still clears busy
        if (wr1_en) begin
          regs_d[wr1_addr] = wr1_data;
          busy_d[wr1_addr] = 1'b0;
        end
        if (wr0_en) begin
          regs_d[wr0_addr] = wr0_data;
        end
        if (sb_set_en) begin
          busy_d[sb_set_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = StSweep;
          idx_d   = ADDR_W'(1);
        end
      end
      StSweep: begin
        regs_d[idx_q] = (idx_q == SpAddr) ? SP_INIT : '0;
        busy_d[idx_q] = 1'b0;
        idx_d         = idx_q + ADDR_W'(1);
        if (idx_q == LastAddr) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      regs_q     <= regs_d;
    end
  end

  // Sweep writes are never forwarded, so bypass only applies while idle
  assign bypass_on = BYPASS && (state_q == StIdle);

  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (bypass_on) begin
        if (wr0_en && (wr0_addr == rd_addr[p])) begin
          rd_data[p] = wr0_data;
        end else if (wr1_en && (wr1_addr == rd_addr[p])) begin
          rd_data[p] = wr1_data;
        end
        if (wr1_en && (wr1_addr == rd_addr[p]) &&
            !(sb_set_en && (sb_set_addr == rd_addr[p]))) begin
          rd_busy[p] = 1'b0;
        end
      end
      if (rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd0_data = rd_data[0];
  assign rd1_data = rd_data[1];
  assign rd0_busy = rd_busy[0];
  assign rd1_busy = rd_busy[1];
  assign clr_busy = (state_q == StSweep);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed steps plus randomized traffic against a
// behavioural model; a second wide, non-bypassing instance covers the parameter corner.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        wr0_en, wr1_en, sb_set_en, clr_req;
  logic [2:0]  wr0_addr, wr1_addr, sb_set_addr, rd0_addr, rd1_addr;
  logic [15:0] wr0_data, wr1_data, rd0_data, rd1_data;
  logic        rd0_busy, rd1_busy, clr_busy, clr_done;

  logic        w_wr0_en, w_clr_req;
  logic [3:0]  w_wr0_addr, w_rd0_addr, w_rd1_addr;
  logic [31:0] w_wr0_data, w_rd0_data, w_rd1_data;
  logic        w_rd0_busy, w_rd1_busy, w_clr_busy, w_clr_done;

  register_file_mp dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  register_file_mp #(
    .DATA_W(32), .ADDR_W(4), .SP_IDX(6), .SP_INIT(32'h0000_0FFF), .BYPASS(1'b0)
  ) dut_w (
    .clk(clk), .reset(reset),
    .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
    .wr1_en(1'b0), .wr1_addr(4'd0), .wr1_data(32'd0),
    .sb_set_en(1'b0), .sb_set_addr(4'd0),
    .rd0_addr(w_rd0_addr), .rd1_addr(w_rd1_addr),
    .rd0_data(w_rd0_data), .rd1_data(w_rd1_data),
    .rd0_busy(w_rd0_busy), .rd1_busy(w_rd1_busy),
    .clr_req(w_clr_req), .clr_busy(w_clr_busy), .clr_done(w_clr_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: plain register array, busy bits, and a countdown of remaining sweep cycles
  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;
  int          m_left;
  logic        m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = (i == 6) ? 16'h0FFF : 16'h0000;
    m_busy = '0;
    m_left = 0;
    m_done = 1'b0;
  endfunction

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (m_left == 0 && wr0_en && wr0_addr == a) return wr0_data;
    if (m_left == 0 && wr1_en && wr1_addr == a) return wr1_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (m_left == 0 && wr1_en && wr1_addr == a && !(sb_set_en && sb_set_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void model_edge();
    int k;
    m_done = 1'b0;
    if (m_left > 0) begin
      k = 8 - m_left;
      m_reg[k]  = (k == 6) ? 16'h0FFF : 16'h0000;
      m_busy[k] = 1'b0;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else begin
      if (wr1_en && wr1_addr != 3'd0) begin
        m_reg[wr1_addr]  = wr1_data;
        m_busy[wr1_addr] = 1'b0;
      end
      if (wr0_en && wr0_addr != 3'd0) m_reg[wr0_addr] = wr0_data;
      if (sb_set_en && sb_set_addr != 3'd0) m_busy[sb_set_addr] = 1'b1;
      if (clr_req) m_left = 7;
    end
  endfunction

  // Inputs are set at the falling edge; check outputs, then take the rising edge
  task automatic cyc();
    #1;
    chk("rd0_data", rd0_data, exp_data(rd0_addr));
    chk("rd1_data", rd1_data, exp_data(rd1_addr));
    chk("rd0_busy", rd0_busy, exp_busy(rd0_addr));
    chk("rd1_busy", rd1_busy, exp_busy(rd1_addr));
    chk("clr_busy", clr_busy, m_left > 0);
    chk("clr_done", clr_done, m_done);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    sb_set_en = 0; sb_set_addr = 0; clr_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, done_cnt;
    idle();
    rd0_addr = 0; rd1_addr = 0;
    w_wr0_en = 0; w_wr0_addr = 0; w_wr0_data = 0; w_clr_req = 0;
    w_rd0_addr = 0; w_rd1_addr = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset image
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(7 - a);
      cyc();
    end
    rd0_addr = 3'd6;
    #1 chk("sp_init", rd0_data, 16'h0FFF);

    // r0 is hardwired
    wr0_en = 1; wr0_addr = 0; wr0_data = 16'hBEEF; rd0_addr = 0;
    cyc();
    idle();
    #1 chk("r0_zero", rd0_data, 16'h0000);
    cyc();

    // port priority with bypass
    wr0_en = 1; wr0_addr = 3; wr0_data = 16'h1111;
    wr1_en = 1; wr1_addr = 3; wr1_data = 16'h2222; rd0_addr = 3;
    #1 chk("byp_prio", rd0_data, 16'h1111);
    cyc();
    idle();
    #1 chk("r3_stored", rd0_data, 16'h1111);
    cyc();

    // scoreboard set / clear / collision
    sb_set_en = 1; sb_set_addr = 5; rd1_addr = 5;
    cyc();
    idle();
    #1 chk("sb_busy", rd1_busy, 1'b1);
    wr1_en = 1; wr1_addr = 5; wr1_data = 16'h00AA;
    #1 chk("sb_clr_byp", rd1_busy, 1'b0);
    chk("ld_byp", rd1_data, 16'h00AA);
    cyc();
    idle();
    sb_set_en = 1; sb_set_addr = 5;
    cyc();
    wr1_en = 1; wr1_addr = 5; wr1_data = 16'h0055;
    #1 chk("sb_set_wins", rd1_busy, 1'b1);
    cyc();
    idle();
    #1 chk("sb_kept", rd1_busy, 1'b1);
    chk("ld_data", rd1_data, 16'h0055);
    cyc();

    // full sweep with a dropped write during it
    for (int a = 1; a < 8; a++) begin
      wr0_en = 1; wr0_addr = 3'(a); wr0_data = 16'hA5A5;
      cyc();
    end
    idle();
    sb_set_en = 1; sb_set_addr = 2;
    cyc();
    idle();
    clr_req = 1;
    cyc();
    idle();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      rd0_addr = 4; rd1_addr = 3'(i);
      #1;
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      wr0_en = clr_busy; wr0_addr = 4; wr0_data = 16'h1234;
      cyc();
    end
    idle();
    chk("sweep_len", busy_cnt, 7);
    chk("done_pulses", done_cnt, 1);
    for (int a = 0; a < 8; a++) begin
      rd0_addr = 3'(a); rd1_addr = 3'(a);
      #1 chk("clr_img", rd0_data, (a == 6) ? 16'h0FFF : 16'h0000);
      chk("clr_busy_bits", rd1_busy, 1'b0);
      cyc();
    end

    // reset in the third sweep cycle
    wr0_en = 1; wr0_addr = 1; wr0_data = 16'h7777;
    cyc();
    idle();
    sb_set_en = 1; sb_set_addr = 3;
    cyc();
    idle();
    clr_req = 1;
    cyc();
    idle();
    cyc();
    cyc();
    #1 chk("pre_rst_busy", clr_busy, 1'b1);
    reset = 1'b1;
    #1 chk("rst_async", clr_busy, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rd0_addr = 3'(i); rd1_addr = 3'(i + 3);
      #1 done_cnt += int'(clr_done);
      cyc();
    end
    chk("no_done", done_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 3'($urandom); wr0_data = 16'($urandom);
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = 3'($urandom); wr1_data = 16'($urandom);
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = 3'($urandom);
      clr_req = ($urandom_range(0, 24) == 0);
      rd0_addr = 3'($urandom); rd1_addr = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rd0_addr = wr1_addr;
      if ($urandom_range(0, 3) == 0) rd1_addr = wr0_addr;
      cyc();
    end
    idle();
    for (int i = 0; i < 10; i++) cyc();

    // wide, non-bypassing instance
    w_wr0_en = 1; w_wr0_addr = 15; w_wr0_data = 32'hDEADBEEF;
    w_rd0_addr = 15; w_rd1_addr = 6;
    #1 chk("w_nobyp", w_rd0_data, 32'h0);
    chk("w_sp", w_rd1_data, 32'h0000_0FFF);
    cyc();
    w_wr0_en = 0;
    #1 chk("w_next", w_rd0_data, 32'hDEADBEEF);
    w_clr_req = 1;
    cyc();
    w_clr_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      #1;
      busy_cnt += int'(w_clr_busy);
      done_cnt += int'(w_clr_done);
      cyc();
    end
    chk("w_sweep_len", busy_cnt, 15);
    chk("w_done", done_cnt, 1);
    #1 chk("w_r15_clr", w_rd0_data, 32'h0);
    chk("w_sp_clr", w_rd1_data, 32'h0000_0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port successor to the CPU's 8x16 register file. It has two write ports: ALU writeback and load return, with fixed priority. It also provides write-to-read bypass, a per-register scoreboard of pending loads, and a sequenced soft-clear engine that restores the reset image without asserting `reset`. It sits between decode (reads, scoreboard checks) and writeback (writes) in the 16-bit datapath.

## Interface
Parameters:
- `DATA_W`, 16, register width
- `ADDR_W`, 3, address width; `NUM_REGS = 2**ADDR_W`
- `SP_IDX`, 6, index of the stack pointer register
- `SP_INIT`, 16'h0FFF, SP reset/clear value (`DATA_W` bits)
- `BYPASS`, 1, 1 = same-cycle write data visible on read ports

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `wr0_en` / `wr0_addr` / `wr0_data`  in  1/ADDR_W/DATA_W  ALU writeback port
- `wr1_en` / `wr1_addr` / `wr1_data`  in  1/ADDR_W/DATA_W  load-return port
- `sb_set_en` / `sb_set_addr`  in  1/ADDR_W  mark register as pending load
- `rd0_addr`, `rd1_addr`  in  ADDR_W  read addresses
- `rd0_data`, `rd1_data`  out  DATA_W  read data (combinational)
- `rd0_busy`, `rd1_busy`  out  1  scoreboard bit of the addressed register
- `clr_req`  in  1  start soft clear (sampled in IDLE only)
- `clr_busy`  out  1  sweep in progress
- `clr_done`  out  1  one-cycle pulse, sweep complete

## Operation
- Register 0 is hardwired to zero.
  - Reads of address 0 return 0 and busy 0.
  - Writes and `sb_set` to address 0 are dropped.
- Writes commit on the rising edge.
  - When `wr0` and `wr1` hit the same address, `wr0` wins; `wr1_data` is discarded.
- Scoreboard:
  - `sb_set_en` sets `busy[sb_set_addr]`.
  - A `wr1` write clears `busy[wr1_addr]`, even if `wr0` won the data.
  - If set and clear target the same address in the same cycle, set wins.
  - `wr0` does not touch busy.
- Bypass (`BYPASS=1`):
  - A read address matching an enabled write port returns that port's data, with the same `wr0` > `wr1` priority.
  - `rdN_busy` reads 0 when `wr1` clears that address this cycle, unless `sb_set` targets it this cycle.
- `BYPASS=0`: reads and busy reflect stored state only.
- Soft-clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on `clr_req`; the index loads 1.
  - Each SWEEP cycle writes register[idx] with `SP_INIT` if `idx==SP_IDX`, else 0, clears `busy[idx]`, and increments idx.
  - When `idx==NUM_REGS-1` it writes, pulses `clr_done` next cycle, and returns to IDLE.
  - Index arithmetic is `ADDR_W` bits; the final increment wraps to 0 and is unused.
  - During SWEEP, `wr0`, `wr1`, `sb_set` and `clr_req` are ignored.
  - Reads during SWEEP return stored contents; sweep writes are never bypassed.
- `clr_busy = (state==SWEEP)`.

## Timing
- Reset (async assert, sync release) sets:
  - all registers 0, except `SP_IDX = SP_INIT`
  - busy all 0
  - state IDLE, idx 0
  - `clr_done` 0, `clr_busy` 0
- Read data is combinational, 0-cycle latency.
  - With `BYPASS=0`, written data is visible the cycle after the edge.
- Write-to-read latency with bypass: same cycle.
- Soft clear:
  - `clr_req` high at edge E. SWEEP occupies cycles E+1 .. E+NUM_REGS-1 (7 cycles for default).
  - `clr_done` is high for exactly the one cycle after the last sweep edge, with `clr_busy` already 0.
  - The next `clr_req` is accepted in that same cycle.
- Reset mid-sweep aborts immediately to the reset image; no `clr_done`.
- `sb_set` and `wr1` on the cycle of `clr_req` (IDLE) are still honoured; SWEEP later clears them.

## Test plan
- Reset, then read all 8 addresses -> only r6 = 0x0FFF, all others 0, all busy 0. Write r0 = 0xBEEF -> r0 still reads 0.
- Same cycle: `wr0` r3=0x1111, `wr1` r3=0x2222, `rd0_addr`=3 -> `rd0_data`=0x1111 in that cycle (`BYPASS=1`); stored r3=0x1111 after the edge.
- `sb_set` r5; the next cycle `rd1_busy`=1. `wr1` r5=0x00AA -> same-cycle `rd1_busy`=0 and `rd1_data`=0x00AA. Repeat with `sb_set` r5 in the same cycle -> busy stays 1.
- Fill r1..r7 with 0xA5A5 and set busy on r2, then pulse `clr_req`:
  - `clr_busy` is high for exactly 7 cycles, and `wr0` r4=0x1234 during the sweep is dropped.
  - `clr_done` pulses once; afterwards all registers are 0, r6 = 0x0FFF, and no busy bits are set.
- Assert `reset` at the 3rd sweep cycle -> `clr_busy` drops asynchronously, `clr_done` never pulses, and the reset image holds.
- `BYPASS=0`, `DATA_W=32`, `ADDR_W=4`:
  - Write r15=0xDEADBEEF and read in the same cycle -> old value 0; the next cycle -> 0xDEADBEEF.
  - A sweep takes 15 cycles.
